// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch handshake between fetch_stage and imem.
// Request/address go out, data/valid come back.
interface fetch_stage_if #(
  parameter int INST_WIDTH_IN_BIT = 32,
  parameter int ADDR_WIDTH        = 32
);
  logic                         imem_req;
  logic [ADDR_WIDTH-1:0]        imem_addr;
  logic [INST_WIDTH_IN_BIT-1:0] imem_rdata;
  logic                         imem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch plus the three-deep instruction window
// (IF/ID, ID/EX, EX/MEM) feeding the hazard controller.
module fetch_stage #(
  parameter int INST_WIDTH_IN_BIT = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [INST_WIDTH_IN_BIT-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_id_if_pl,
  input  logic                         stall_pc_increment,
  input  logic                         halt,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  fetch_stage_if.master                imem,
  output logic [INST_WIDTH_IN_BIT-1:0] next_inst,
  output logic [INST_WIDTH_IN_BIT-1:0] curr_inst,
  output logic [INST_WIDTH_IN_BIT-1:0] prev_inst,
  output logic [ADDR_WIDTH-1:0]        if_pc,
  output logic [31:0]                  fetch_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  run;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] target;

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = halt ? HALTED : RUN;
      RUN:     state_nxt = halt ? HALTED : RUN;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = BOOT;
    endcase
  end

  // halt wins over everything, so it gates the whole RUN datapath
  assign run    = (state == RUN) && !halt;
  assign accept = run && imem.imem_rvalid
               && !stall_pc_increment && !redirect_valid;
  assign target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  assign imem.imem_req  = (state == RUN);
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_pc       <= RESET_PC;
      next_inst   <= NOP_INST;
      curr_inst   <= NOP_INST;
      prev_inst   <= NOP_INST;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (run) begin
        prev_inst <= curr_inst;
        curr_inst <= stall_id_if_pl ? NOP_INST : next_inst;
        if (redirect_valid) begin
          next_inst <= NOP_INST;
          pc        <= target;
        end else begin
          if (accept)
            pc <= pc + ADDR_WIDTH'(4);
          if (!stall_id_if_pl) begin
            next_inst <= accept ? imem.imem_rdata : NOP_INST;
            if (accept)
              if_pc <= pc;
          end
        end
        if (accept)
          fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a cycle-level
// behavioural model of the fetch window.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_id_if_pl;
  logic        stall_pc_increment;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] next_inst;
  logic [31:0] curr_inst;
  logic [31:0] prev_inst;
  logic [31:0] if_pc;
  logic [31:0] fetch_count;

  fetch_stage_if #(.INST_WIDTH_IN_BIT(32), .ADDR_WIDTH(32)) imem ();

  fetch_stage #(
    .INST_WIDTH_IN_BIT(32),
    .ADDR_WIDTH(32),
    .RESET_PC(RPC),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall_id_if_pl(stall_id_if_pl),
    .stall_pc_increment(stall_pc_increment),
    .halt(halt),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem(imem.master),
    .next_inst(next_inst),
    .curr_inst(curr_inst),
    .prev_inst(prev_inst),
    .if_pc(if_pc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: cycles since reset and a sticky halt flag
  bit          m_booted, m_halted;
  logic [31:0] m_pc, m_ifpc, m_next, m_curr, m_prev, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booted = 0;
    m_halted = 0;
    m_pc     = RPC;
    m_ifpc   = RPC;
    m_next   = NOP;
    m_curr   = NOP;
    m_prev   = NOP;
    m_cnt    = 0;
  endtask

  task automatic model_edge();
    bit          acc;
    logic [31:0] o_next, o_curr;
    if (m_halted) return;
    if (halt) begin
      m_halted = 1;
      return;
    end
    if (!m_booted) begin
      m_booted = 1;
      return;
    end
    acc = imem.imem_rvalid && !stall_pc_increment && !redirect_valid;
    o_next = m_next;
    o_curr = m_curr;
    m_prev = o_curr;
    m_curr = stall_id_if_pl ? NOP : o_next;
    if (redirect_valid) begin
      m_next = NOP;
      m_pc   = redirect_pc & ~32'd3;
    end else if (!stall_id_if_pl) begin
      m_next = acc ? imem.imem_rdata : NOP;
      if (acc) m_ifpc = m_pc;
    end
    if (acc) begin
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic check_all();
    chk("req",  {31'd0, imem.imem_req}, {31'd0, m_booted && !m_halted});
    chk("addr", imem.imem_addr, m_pc);
    chk("next", next_inst, m_next);
    chk("curr", curr_inst, m_curr);
    chk("prev", prev_inst, m_prev);
    chk("ifpc", if_pc, m_ifpc);
    chk("cnt",  fetch_count, m_cnt);
  endtask

  task automatic drive(input bit rv, input bit sid, input bit spc,
                       input bit hl, input bit rd,
                       input logic [31:0] rpc);
    imem.imem_rvalid   = rv;
    imem.imem_rdata    = $urandom;
    stall_id_if_pl     = sid;
    stall_pc_increment = spc;
    halt               = hl;
    redirect_valid     = rd;
    redirect_pc        = rpc;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // asynchronous reset asserted between clock edges
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_req",  {31'd0, imem.imem_req}, 32'd0);
    chk("rst_addr", imem.imem_addr, RPC);
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // straight-line fetch: boot cycle then 0x100, 0x104, 0x108
    step();
    chk("boot_addr", imem.imem_addr, 32'h100);
    step();
    chk("addr1", imem.imem_addr, 32'h104);
    step();
    chk("addr2", imem.imem_addr, 32'h108);
    step();
    chk("cnt3", fetch_count, 32'd3);

    // ID stall with PC hold for two cycles
    drive(1, 1, 1, 0, 0, 0);
    step();
    chk("stall_curr", curr_inst, NOP);
    drive(1, 1, 1, 0, 0, 0);
    step();
    chk("stall_prev", prev_inst, NOP);

    // wait states at 0x200
    drive(1, 0, 0, 0, 1, 32'h200);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("ws_addr", imem.imem_addr, 32'h200);
      chk("ws_next", next_inst, NOP);
    end
    drive(1, 0, 0, 0, 0, 0);
    step();
    chk("ws_pc", imem.imem_addr, 32'h204);

    // redirect racing returned data
    drive(1, 0, 0, 0, 1, 32'h3E7);
    step();
    chk("rd_addr", imem.imem_addr, 32'h3E4);
    chk("rd_next", next_inst, NOP);

    // pc wrap
    drive(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step();
    drive(1, 0, 0, 0, 0, 0);
    step();
    chk("pc_wrap", imem.imem_addr, 32'h0);

    // fetch_count wrap
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    m_cnt = 32'hFFFF_FFFF;
    drive(1, 0, 0, 0, 0, 0);
    step();
    chk("cnt_wrap", fetch_count, 32'h0);

    // halt pulse then everything frozen
    drive(1, 0, 0, 1, 0, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom);
      step();
    end
    chk("halt_req", {31'd0, imem.imem_req}, 32'd0);
    do_reset();

    // random traffic with occasional halt and reset
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 249) do_reset();
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 400) == 0,
            $urandom_range(0, 7) == 0,
            $urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
